csr_exc_pipe: RTL and testbench
===============================

CSR_EXC_PIPE -- requirements
Module: csr_exc_pipe

Interface
REQ-001 SHALL take parameters: LANES, default 2, issue lanes (lane 0 oldest); ECODE_W, default 7, exception code width; CSR_AW, default 14, CSR address width.
REQ-002 SHALL have one clock and a synchronous, active-low reset: clk  in  1  rising-edge clock; rstn  in  1  synchronous active-low reset.
REQ-003 SHALL have inputs: stall  in  1  freeze all stages; flush_in  in  1  branch flush, EX->MEM; mem_kill  in  LANES  combinational MEM lane suppress; irq  in  1  interrupt request level.
REQ-004 SHALL have EX inputs: ex_valid  in  LANES; ex_exc  in  LANES  lane exception; ex_ecode  in  LANES*ECODE_W; ex_badv_we  in  LANES; ex_badv  in  LANES*32; ex_pc  in  LANES*32.
REQ-005 SHALL have bundle EX inputs: ex_csr_we  in  32  bit-write mask; ex_csr_waddr  in  CSR_AW; ex_csr_wdata  in  32; ex_ertn  in  1.
REQ-006 SHALL have outputs: mem_valid  out  LANES  effective MEM valid; irq_pending  out  1  buffered interrupt; wb_exc  out  1; wb_ecode  out  ECODE_W; wb_badv_we  out  1; wb_badv  out  32; wb_era  out  32; wb_csr_we  out  32; wb_csr_waddr  out  CSR_AW; wb_csr_wdata  out  32; wb_ertn  out  1; wb_flush  out  1; wb_flush_pc  out  32.

Function
REQ-007 SHALL register EX->MEM on every edge where stall=0; stall=1 SHALL hold the MEM register.
REQ-008 SHALL clear the MEM valid, exc, csr_we and ertn registers on any edge where flush_in=1 or wb_flush=1, regardless of stall.
REQ-009 SHALL drive mem_valid[i] = mem_reg_valid[i] & ~mem_kill[i] & ~wb_flush.
REQ-010 SHALL force lane i's exception and badv_we to 0 when mem_valid[i]=0.
REQ-011 SHALL treat the interrupt as taken when (irq | irq_pending) & (|mem_valid) & ~stall.
REQ-012 SHALL give the MEM event priority: taken interrupt, then lowest-index valid lane with exc, then ertn of any valid lane.
REQ-013 SHALL attach a taken interrupt to the lowest-index valid lane: ecode 0, badv_we 0, era = that lane's pc.
REQ-014 SHALL, for a lane exception, take ecode, badv and badv_we from the selected lane, with era = that lane's pc.
REQ-015 SHALL zero the CSR write mask and ertn whenever an exception or interrupt is selected.
REQ-016 SHALL update WB on an edge with stall=0: wb_exc = exception or interrupt selected; wb_ertn; wb_csr_we; wb_flush = wb_exc | wb_ertn; wb_flush_pc = era.
REQ-017 SHALL make wb_exc, wb_ertn, wb_csr_we and wb_flush one-cycle strobes; on an edge with stall=1 they go to 0 and WB data holds.
REQ-018 SHALL register WB data (ecode, badv, era, csr addr/data) only on edges where stall=0.
REQ-019 SHALL ignore the MEM stage while wb_flush=1; all lanes read as invalid, so no second event is generated.
REQ-020 SHALL give latency EX->WB of exactly 2 unstalled edges.

Reset
REQ-021 SHALL, on an edge with rstn=0, clear: all MEM valid/exc/csr_we/ertn registers, irq_pending, every wb_* output, and wb_flush_pc to 0; MEM data registers need no reset.
REQ-022 SHALL let reset override stall, flush_in and wb_flush; reset mid-stall or mid-flush yields all-zero outputs on the next edge.

Configuration
REQ-023 SHALL use macro CSR_EXC_PIPE_IRQ_BUF_EN.
REQ-024 SHALL, when CSR_EXC_PIPE_IRQ_BUF_EN is defined: set irq_pending on an unstalled edge with irq=1 and no mem_valid lane, or with wb_flush=1 caused by a non-interrupt event; clear it when the interrupt is taken.
REQ-025 SHALL, when CSR_EXC_PIPE_IRQ_BUF_EN is undefined: tie irq_pending to 0 and take the interrupt only via irq in a cycle with a valid MEM lane.

Verification
REQ-026 SHALL cover: lane1 exc ecode=0x09, pc=0x1C000008, lane0 clean -> 2 edges later wb_exc=1, wb_ecode=0x09, wb_era=0x1C000008, wb_flush=1 for 1 cycle, wb_csr_we=0.
REQ-027 SHALL cover: both lanes exc (ecodes 0x08, 0x09) -> wb_ecode=0x08, wb_era=lane0 pc.
REQ-028 SHALL cover: irq=1 for one cycle with MEM empty, then lane0 valid two cycles later -> with macro: wb_exc=1, wb_ecode=0, irq_pending cleared; without macro: no event.
REQ-029 SHALL cover: csr_we=0xFFFFFFFF, addr=0x005, stall=1 for 3 cycles -> wb_csr_we asserted exactly once, after stall drops.
REQ-030 SHALL cover: mem_kill=2'b10 with lane1 exc -> no wb_exc; flush_in with ertn in EX -> wb_ertn never asserted.
REQ-031 SHALL cover: rstn=0 during wb_flush=1 -> all outputs 0 next edge, irq_pending=0.

Source files
------------

// File: rtl/csr_exc_pipe.sv
// Two-lane EX->MEM->WB exception/CSR commit pipe; lowest valid lane wins, interrupts first, then exceptions, then ertn.
// Latency 2 unstalled edges EX->WB; stall freezes MEM and turns WB strobes into zeros; optional CSR_EXC_PIPE_IRQ_BUF_EN latches lost interrupts.
module csr_exc_pipe #(
    parameter int LANES   = 2,
    parameter int ECODE_W = 7,
    parameter int CSR_AW  = 14
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       stall,
    input  logic                       flush_in,
    input  logic [LANES-1:0]           mem_kill,
    input  logic                       irq,
    input  logic [LANES-1:0]           ex_valid,
    input  logic [LANES-1:0]           ex_exc,
    input  logic [LANES*ECODE_W-1:0]   ex_ecode,
    input  logic [LANES-1:0]           ex_badv_we,
    input  logic [LANES*32-1:0]        ex_badv,
    input  logic [LANES*32-1:0]        ex_pc,
    input  logic [31:0]                ex_csr_we,
    input  logic [CSR_AW-1:0]          ex_csr_waddr,
    input  logic [31:0]                ex_csr_wdata,
    input  logic                       ex_ertn,
    output logic [LANES-1:0]           mem_valid,
    output logic                       irq_pending,
    output logic                       wb_exc,
    output logic [ECODE_W-1:0]         wb_ecode,
    output logic                       wb_badv_we,
    output logic [31:0]                wb_badv,
    output logic [31:0]                wb_era,
    output logic [31:0]                wb_csr_we,
    output logic [CSR_AW-1:0]          wb_csr_waddr,
    output logic [31:0]                wb_csr_wdata,
    output logic                       wb_ertn,
    output logic                       wb_flush,
    output logic [31:0]                wb_flush_pc
);

    logic [LANES-1:0]         mem_reg_valid, mem_reg_exc, mem_reg_badv_we;
    logic [LANES*ECODE_W-1:0] mem_reg_ecode;
    logic [LANES*32-1:0]      mem_reg_badv, mem_reg_pc;
    logic [31:0]              mem_reg_csr_we, mem_reg_csr_wdata;
    logic [CSR_AW-1:0]        mem_reg_csr_waddr;
    logic                     mem_reg_ertn;

    logic [LANES-1:0]   lane_exc;
    logic               any_valid, any_exc, irq_src, irq_take;
    logic [31:0]        first_pc, exc_pc, exc_badv;
    logic [ECODE_W-1:0] exc_ecode;
    logic               exc_badv_we;
    logic               sel_exc, sel_ertn;
    logic [31:0]        sel_csr_we;

    // Control bits are cleared by flush; data just follows EX when unstalled.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mem_reg_valid  <= '0;
            mem_reg_exc    <= '0;
            mem_reg_csr_we <= '0;
            mem_reg_ertn   <= 1'b0;
        end else if (flush_in || wb_flush) begin
            mem_reg_valid  <= '0;
            mem_reg_exc    <= '0;
            mem_reg_csr_we <= '0;
            mem_reg_ertn   <= 1'b0;
        end else if (!stall) begin
            mem_reg_valid  <= ex_valid;
            mem_reg_exc    <= ex_exc;
            mem_reg_csr_we <= ex_csr_we;
            mem_reg_ertn   <= ex_ertn;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            mem_reg_ecode     <= ex_ecode;
            mem_reg_badv_we   <= ex_badv_we;
            mem_reg_badv      <= ex_badv;
            mem_reg_pc        <= ex_pc;
            mem_reg_csr_waddr <= ex_csr_waddr;
            mem_reg_csr_wdata <= ex_csr_wdata;
        end
    end

    assign mem_valid = mem_reg_valid & ~mem_kill & {LANES{~wb_flush}};
    assign lane_exc  = mem_reg_exc & mem_valid;
    assign any_valid = |mem_valid;
    assign any_exc   = |lane_exc;
    assign irq_take  = irq_src & any_valid & ~stall;

`ifdef CSR_EXC_PIPE_IRQ_BUF_EN
    logic irq_pend_q, wb_irq;

    // Remember an interrupt that arrived with nothing to attach to, or behind a non-interrupt flush.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            irq_pend_q <= 1'b0;
            wb_irq     <= 1'b0;
        end else if (!stall) begin
            wb_irq <= irq_take;
            if (irq_take)
                irq_pend_q <= 1'b0;
            else if (irq && (!any_valid || (wb_flush && !wb_irq)))
                irq_pend_q <= 1'b1;
        end
    end

    assign irq_pending = irq_pend_q;
    assign irq_src     = irq | irq_pend_q;
`else
    assign irq_pending = 1'b0;
    assign irq_src     = irq;
`endif

    // Walk from the youngest lane down so the oldest matching lane wins.
    always_comb begin
        first_pc    = '0;
        exc_pc      = '0;
        exc_badv    = '0;
        exc_ecode   = '0;
        exc_badv_we = 1'b0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mem_valid[i])
                first_pc = mem_reg_pc[i*32 +: 32];
            if (lane_exc[i]) begin
                exc_pc      = mem_reg_pc[i*32 +: 32];
                exc_badv    = mem_reg_badv[i*32 +: 32];
                exc_ecode   = mem_reg_ecode[i*ECODE_W +: ECODE_W];
                exc_badv_we = mem_reg_badv_we[i];
            end
        end
    end

    assign sel_exc    = irq_take | any_exc;
    assign sel_ertn   = ~sel_exc & mem_reg_ertn & any_valid;
    assign sel_csr_we = (sel_exc || !any_valid) ? '0 : mem_reg_csr_we;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wb_exc       <= 1'b0;
            wb_ecode     <= '0;
            wb_badv_we   <= 1'b0;
            wb_badv      <= '0;
            wb_era       <= '0;
            wb_csr_we    <= '0;
            wb_csr_waddr <= '0;
            wb_csr_wdata <= '0;
            wb_ertn      <= 1'b0;
            wb_flush     <= 1'b0;
            wb_flush_pc  <= '0;
        end else if (stall) begin
            wb_exc    <= 1'b0;
            wb_csr_we <= '0;
            wb_ertn   <= 1'b0;
            wb_flush  <= 1'b0;
        end else begin
            wb_exc       <= sel_exc;
            wb_ecode     <= irq_take ? '0 : exc_ecode;
            wb_badv_we   <= irq_take ? 1'b0 : exc_badv_we;
            wb_badv      <= exc_badv;
            wb_era       <= (any_exc && !irq_take) ? exc_pc : first_pc;
            wb_csr_we    <= sel_csr_we;
            wb_csr_waddr <= mem_reg_csr_waddr;
            wb_csr_wdata <= mem_reg_csr_wdata;
            wb_ertn      <= sel_ertn;
            wb_flush     <= sel_exc | sel_ertn;
            wb_flush_pc  <= (any_exc && !irq_take) ? exc_pc : first_pc;
        end
    end

endmodule

// File: tb/tb_csr_exc_pipe.sv
// Self-checking bench for csr_exc_pipe: directed scenarios plus a randomized run against a transaction-level model.
module tb_csr_exc_pipe;

    logic        clk, rstn, stall, flush_in, irq, ex_ertn;
    logic [1:0]  mem_kill, ex_valid, ex_exc, ex_badv_we;
    logic [13:0] ex_ecode, ex_csr_waddr;
    logic [63:0] ex_badv, ex_pc;
    logic [31:0] ex_csr_we, ex_csr_wdata;
    logic [1:0]  mem_valid;
    logic        irq_pending, wb_exc, wb_badv_we, wb_ertn, wb_flush;
    logic [6:0]  wb_ecode;
    logic [31:0] wb_badv, wb_era, wb_csr_we, wb_csr_wdata, wb_flush_pc;
    logic [13:0] wb_csr_waddr;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef CSR_EXC_PIPE_IRQ_BUF_EN
    localparam bit IRQ_BUF = 1'b1;
`else
    localparam bit IRQ_BUF = 1'b0;
`endif

    csr_exc_pipe dut (
        .clk(clk), .rstn(rstn), .stall(stall), .flush_in(flush_in), .mem_kill(mem_kill), .irq(irq),
        .ex_valid(ex_valid), .ex_exc(ex_exc), .ex_ecode(ex_ecode), .ex_badv_we(ex_badv_we),
        .ex_badv(ex_badv), .ex_pc(ex_pc), .ex_csr_we(ex_csr_we), .ex_csr_waddr(ex_csr_waddr),
        .ex_csr_wdata(ex_csr_wdata), .ex_ertn(ex_ertn), .mem_valid(mem_valid), .irq_pending(irq_pending),
        .wb_exc(wb_exc), .wb_ecode(wb_ecode), .wb_badv_we(wb_badv_we), .wb_badv(wb_badv), .wb_era(wb_era),
        .wb_csr_we(wb_csr_we), .wb_csr_waddr(wb_csr_waddr), .wb_csr_wdata(wb_csr_wdata), .wb_ertn(wb_ertn),
        .wb_flush(wb_flush), .wb_flush_pc(wb_flush_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; flush_in = 0; mem_kill = 0; irq = 0; ex_valid = 0; ex_exc = 0; ex_ecode = 0;
        ex_badv_we = 0; ex_badv = 0; ex_pc = 0; ex_csr_we = 0; ex_csr_waddr = 0; ex_csr_wdata = 0; ex_ertn = 0;
    endtask

    task automatic drain();
        idle();
        tick(); tick(); tick();
    endtask

    task automatic test_reset();
        idle();
        rstn = 0; stall = 1; irq = 1; ex_valid = 2'b11;
        tick(); tick();
        n_checks++; if (mem_valid !== 2'b00) begin n_fail++; $display("FAIL reset_mem_valid got=%b exp=00", mem_valid); end
        n_checks++; if ({wb_exc, wb_ertn, wb_flush, wb_badv_we, irq_pending} !== 5'b0) begin n_fail++; $display("FAIL reset_strobes got=%b exp=0", {wb_exc, wb_ertn, wb_flush, wb_badv_we, irq_pending}); end
        n_checks++; if ({wb_csr_we, wb_era, wb_flush_pc} !== 96'b0) begin n_fail++; $display("FAIL reset_data got=%h/%h/%h exp=0", wb_csr_we, wb_era, wb_flush_pc); end
        idle();
        rstn = 1;
        tick();
    endtask

    task automatic test_lane1_exc();
        ex_valid = 2'b11; ex_exc = 2'b10; ex_ecode = {7'h09, 7'h00}; ex_pc = {32'h1C000008, 32'h1C000004};
        ex_csr_we = 32'h0000_1234;
        tick();
        idle();
        n_checks++; if (mem_valid !== 2'b11) begin n_fail++; $display("FAIL l1exc_mem_valid got=%b exp=11", mem_valid); end
        tick();
        n_checks++; if (wb_exc !== 1'b1 || wb_flush !== 1'b1) begin n_fail++; $display("FAIL l1exc_strobe got=%b%b exp=11", wb_exc, wb_flush); end
        n_checks++; if (wb_ecode !== 7'h09) begin n_fail++; $display("FAIL l1exc_ecode got=%h exp=09", wb_ecode); end
        n_checks++; if (wb_era !== 32'h1C000008 || wb_flush_pc !== 32'h1C000008) begin n_fail++; $display("FAIL l1exc_era got=%h/%h exp=1c000008", wb_era, wb_flush_pc); end
        n_checks++; if (wb_csr_we !== 32'h0) begin n_fail++; $display("FAIL l1exc_csr_we got=%h exp=0", wb_csr_we); end
        tick();
        n_checks++; if (wb_exc !== 1'b0 || wb_flush !== 1'b0) begin n_fail++; $display("FAIL l1exc_one_cycle got=%b%b exp=00", wb_exc, wb_flush); end
        drain();
    endtask

    task automatic test_both_exc();
        ex_valid = 2'b11; ex_exc = 2'b11; ex_ecode = {7'h09, 7'h08}; ex_pc = {32'h1C000104, 32'h1C000100};
        ex_badv_we = 2'b01; ex_badv = {32'hBBBB0000, 32'hAAAA0000};
        tick(); idle(); tick();
        n_checks++; if (wb_exc !== 1'b1 || wb_ecode !== 7'h08) begin n_fail++; $display("FAIL both_ecode got=%b/%h exp=1/08", wb_exc, wb_ecode); end
        n_checks++; if (wb_era !== 32'h1C000100) begin n_fail++; $display("FAIL both_era got=%h exp=1c000100", wb_era); end
        n_checks++; if (wb_badv_we !== 1'b1 || wb_badv !== 32'hAAAA0000) begin n_fail++; $display("FAIL both_badv got=%b/%h exp=1/aaaa0000", wb_badv_we, wb_badv); end
        drain();
    endtask

    task automatic test_irq();
        irq = 1;
        tick();
        irq = 0;
        n_checks++; if (irq_pending !== IRQ_BUF) begin n_fail++; $display("FAIL irq_buffered got=%b exp=%b", irq_pending, IRQ_BUF); end
        tick();
        ex_valid = 2'b01; ex_pc = {32'h0, 32'h1C000010};
        tick(); idle(); tick();
        n_checks++; if (wb_exc !== IRQ_BUF || wb_flush !== IRQ_BUF) begin n_fail++; $display("FAIL irq_taken got=%b%b exp=%b", wb_exc, wb_flush, IRQ_BUF); end
        if (IRQ_BUF) begin
            n_checks++; if (wb_ecode !== 7'h0 || wb_era !== 32'h1C000010) begin n_fail++; $display("FAIL irq_ecode_era got=%h/%h exp=00/1c000010", wb_ecode, wb_era); end
        end
        n_checks++; if (irq_pending !== 1'b0) begin n_fail++; $display("FAIL irq_cleared got=%b exp=0", irq_pending); end
        drain();
    endtask

    task automatic test_csr_stall();
        int seen = 0;
        ex_valid = 2'b01; ex_csr_we = 32'hFFFFFFFF; ex_csr_waddr = 14'h005; ex_csr_wdata = 32'hA5A5_5A5A;
        tick();
        idle(); stall = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (wb_csr_we !== 32'h0) seen++;
        end
        stall = 0;
        tick();
        n_checks++; if (wb_csr_we !== 32'hFFFFFFFF || wb_csr_waddr !== 14'h005 || wb_csr_wdata !== 32'hA5A55A5A) begin n_fail++; $display("FAIL csr_after_stall got=%h/%h/%h exp=ffffffff/0005/a5a55a5a", wb_csr_we, wb_csr_waddr, wb_csr_wdata); end
        if (wb_csr_we !== 32'h0) seen++;
        tick();
        if (wb_csr_we !== 32'h0) seen++;
        n_checks++; if (seen !== 1) begin n_fail++; $display("FAIL csr_once got=%0d exp=1", seen); end
        drain();
    endtask

    task automatic test_kill_flush();
        int seen = 0;
        ex_valid = 2'b11; ex_exc = 2'b10; ex_ecode = {7'h0C, 7'h00};
        tick(); idle(); mem_kill = 2'b10; #2;
        n_checks++; if (mem_valid !== 2'b01) begin n_fail++; $display("FAIL kill_mem_valid got=%b exp=01", mem_valid); end
        tick(); mem_kill = 0;
        n_checks++; if (wb_exc !== 1'b0 || wb_flush !== 1'b0) begin n_fail++; $display("FAIL kill_no_exc got=%b%b exp=00", wb_exc, wb_flush); end
        drain();
        ex_valid = 2'b01; ex_ertn = 1;
        tick(); idle(); tick();
        n_checks++; if (wb_ertn !== 1'b1 || wb_flush !== 1'b1) begin n_fail++; $display("FAIL ertn_plain got=%b%b exp=11", wb_ertn, wb_flush); end
        drain();
        ex_valid = 2'b01; ex_ertn = 1; flush_in = 1;
        tick(); idle();
        for (int k = 0; k < 3; k++) begin
            tick();
            if (wb_ertn !== 1'b0) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL ertn_flushed got=%0d exp=0", seen); end
        drain();
    endtask

    task automatic test_reset_in_flush();
        ex_valid = 2'b01; ex_exc = 2'b01; ex_ecode = 14'h0005; ex_pc = {32'h0, 32'h1C000200};
        tick(); idle(); tick();
        n_checks++; if (wb_flush !== 1'b1) begin n_fail++; $display("FAIL rstflush_pre got=%b exp=1", wb_flush); end
        rstn = 0; stall = 1; irq = 1; ex_valid = 2'b11;
        tick();
        n_checks++; if ({wb_exc, wb_flush, wb_ertn, wb_badv_we, irq_pending, mem_valid} !== 7'b0) begin n_fail++; $display("FAIL rstflush_strobes got=%b exp=0", {wb_exc, wb_flush, wb_ertn, wb_badv_we, irq_pending, mem_valid}); end
        n_checks++; if ({wb_ecode, wb_era, wb_flush_pc, wb_csr_we} !== 103'b0) begin n_fail++; $display("FAIL rstflush_data got=%h/%h/%h exp=0", wb_ecode, wb_era, wb_flush_pc); end
        idle(); rstn = 1;
        tick();
    endtask

    task automatic test_random();
        logic [1:0]  m_valid, m_exc, m_bwe, eff, xl;
        logic [13:0] m_ecode, m_waddr;
        logic [63:0] m_badv, m_pc;
        logic [31:0] m_csr, m_wdata;
        logic        m_ertn;
        logic        e_exc, e_bwe, e_ertn, e_flush, e_irq, e_pend, old_flush, take, isrc;
        logic [6:0]  e_ecode;
        logic [31:0] e_badv, e_era, e_csr, e_wdata;
        logic [13:0] e_waddr;
        int ln;
        m_valid = 0; m_exc = 0; m_bwe = 0; m_ecode = 0; m_waddr = 0; m_badv = 0; m_pc = 0; m_csr = 0; m_wdata = 0; m_ertn = 0;
        e_exc = 0; e_bwe = 0; e_ertn = 0; e_flush = 0; e_irq = 0; e_pend = 0; e_ecode = 0;
        e_badv = 0; e_era = 0; e_csr = 0; e_wdata = 0; e_waddr = 0;
        idle(); rstn = 0; tick(); rstn = 1;
        for (int c = 0; c < 600; c++) begin
            stall      = ($urandom_range(3) == 0);
            flush_in   = ($urandom_range(9) == 0);
            irq        = ($urandom_range(6) == 0);
            mem_kill   = ($urandom_range(4) == 0) ? 2'($urandom) : 2'b00;
            ex_valid   = 2'($urandom);
            ex_exc     = {($urandom_range(3) == 0), ($urandom_range(3) == 0)};
            ex_ecode   = 14'($urandom);
            ex_badv_we = 2'($urandom);
            ex_badv    = {$urandom, $urandom};
            ex_pc      = {$urandom, $urandom};
            ex_csr_we  = $urandom_range(1) ? $urandom : 32'h0;
            ex_csr_waddr = 14'($urandom);
            ex_csr_wdata = $urandom;
            ex_ertn    = ($urandom_range(7) == 0);
            #2;
            eff = e_flush ? 2'b00 : (m_valid & ~mem_kill);
            n_checks++; if (mem_valid !== eff) begin n_fail++; $display("FAIL rnd_mem_valid c=%0d got=%b exp=%b", c, mem_valid, eff); end
            n_checks++; if (irq_pending !== e_pend) begin n_fail++; $display("FAIL rnd_irq_pending c=%0d got=%b exp=%b", c, irq_pending, e_pend); end
            isrc = IRQ_BUF ? (irq | e_pend) : irq;
            take = isrc && (eff != 0) && !stall;
            xl = m_exc & eff;
            old_flush = e_flush;
            if (!stall) begin
                if (IRQ_BUF) begin
                    if (take) e_pend = 0;
                    else if (irq && (eff == 0 || (e_flush && !e_irq))) e_pend = 1;
                end
                e_irq = take;
                if (take) begin
                    ln = eff[0] ? 0 : 1;
                    e_exc = 1; e_ecode = 0; e_bwe = 0; e_era = m_pc[ln*32 +: 32]; e_ertn = 0; e_csr = 0;
                end else if (xl != 0) begin
                    ln = xl[0] ? 0 : 1;
                    e_exc = 1; e_ecode = m_ecode[ln*7 +: 7]; e_bwe = m_bwe[ln]; e_badv = m_badv[ln*32 +: 32];
                    e_era = m_pc[ln*32 +: 32]; e_ertn = 0; e_csr = 0;
                end else begin
                    e_exc = 0; e_bwe = 0; e_ertn = m_ertn && (eff != 0); e_csr = (eff != 0) ? m_csr : 32'h0;
                end
                e_flush = e_exc | e_ertn;
                e_waddr = m_waddr; e_wdata = m_wdata;
            end else begin
                e_exc = 0; e_ertn = 0; e_csr = 0; e_flush = 0;
            end
            if (flush_in || old_flush) begin
                m_valid = 0; m_exc = 0; m_csr = 0; m_ertn = 0;
            end else if (!stall) begin
                m_valid = ex_valid; m_exc = ex_exc; m_csr = ex_csr_we; m_ertn = ex_ertn; m_ecode = ex_ecode;
                m_bwe = ex_badv_we; m_badv = ex_badv; m_pc = ex_pc; m_waddr = ex_csr_waddr; m_wdata = ex_csr_wdata;
            end
            tick();
            n_checks++; if ({wb_exc, wb_ertn, wb_flush, wb_badv_we} !== {e_exc, e_ertn, e_flush, e_bwe}) begin n_fail++; $display("FAIL rnd_strobes c=%0d got=%b exp=%b", c, {wb_exc, wb_ertn, wb_flush, wb_badv_we}, {e_exc, e_ertn, e_flush, e_bwe}); end
            n_checks++; if (wb_csr_we !== e_csr) begin n_fail++; $display("FAIL rnd_csr_we c=%0d got=%h exp=%h", c, wb_csr_we, e_csr); end
            if (e_exc) begin
                n_checks++; if (wb_ecode !== e_ecode || wb_era !== e_era || wb_flush_pc !== e_era) begin n_fail++; $display("FAIL rnd_event c=%0d got=%h/%h/%h exp=%h/%h", c, wb_ecode, wb_era, wb_flush_pc, e_ecode, e_era); end
                if (e_bwe) begin
                    n_checks++; if (wb_badv !== e_badv) begin n_fail++; $display("FAIL rnd_badv c=%0d got=%h exp=%h", c, wb_badv, e_badv); end
                end
            end
            if (e_csr != 0) begin
                n_checks++; if (wb_csr_waddr !== e_waddr || wb_csr_wdata !== e_wdata) begin n_fail++; $display("FAIL rnd_csr_data c=%0d got=%h/%h exp=%h/%h", c, wb_csr_waddr, wb_csr_wdata, e_waddr, e_wdata); end
            end
        end
        drain();
    endtask

    initial begin
        idle();
        rstn = 0;
        test_reset();
        test_lane1_exc();
        test_both_exc();
        test_irq();
        test_csr_stall();
        test_kill_flush();
        test_reset_in_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
